// File: rtl/imem_uart_loader.sv
// imem_uart_loader: receives a program image over UART and writes it into the
// CPU instruction memory, holding the CPU in reset until a complete,
// checksum-verified image has been stored.
//
// Image: 0x4C, count_hi, count_lo, N x 4 data bytes (MSB first), XOR checksum.
//
// Ports:
//   clk_in      system clock, rising edge
//   reset       synchronous active-high reset
//   rx          UART serial input, idle high, asynchronous
//   load_en     load request level
//   imem_we     instruction-memory write strobe, one cycle per word
//   imem_addr   word address of the current write
//   imem_wdata  word being written
//   cpu_reset   CPU core reset, high while loading
//   load_done   image accepted, CPU released
//   load_err    sticky error flag
//   word_count  words written in the current load
module imem_uart_loader #(
    parameter int unsigned CLKS_PER_BIT = 868,
    parameter int unsigned ADDR_W       = 11
) (
    input  logic              clk_in,
    input  logic              reset,
    input  logic              rx,
    input  logic              load_en,
    output logic              imem_we,
    output logic [ADDR_W-1:0] imem_addr,
    output logic [31:0]       imem_wdata,
    output logic              cpu_reset,
    output logic              load_done,
    output logic              load_err,
    output logic [ADDR_W:0]   word_count
);

    localparam int unsigned CNT_W     = $clog2(CLKS_PER_BIT);
    localparam int unsigned WC_W      = ADDR_W + 1;
    localparam int unsigned MAX_WORDS = 1 << ADDR_W;
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'(CLKS_PER_BIT / 2 - 1);
    localparam logic [7:0] HDR_BYTE = 8'h4C;

    // ------------------------------------------------------------------
    // UART receiver
    // ------------------------------------------------------------------
    typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;

    rx_state_t        rx_state_q;
    logic             rx_s1_q, rx_s2_q, rx_prev_q;
    logic [CNT_W-1:0] rx_cnt_q;
    logic [2:0]       rx_bit_q;
    logic [7:0]       rx_shift_q;
    logic             byte_valid_q, frame_err_q;

    // rx_prev_q delays the synchronized line so only a true falling edge starts a frame
    always_ff @(posedge clk_in) begin
        if (reset) begin
            rx_s1_q      <= 1'b1;
            rx_s2_q      <= 1'b1;
            rx_prev_q    <= 1'b1;
            rx_state_q   <= RX_IDLE;
            rx_cnt_q     <= '0;
            rx_bit_q     <= '0;
            rx_shift_q   <= '0;
            byte_valid_q <= 1'b0;
            frame_err_q  <= 1'b0;
        end else begin
            rx_s1_q      <= rx;
            rx_s2_q      <= rx_s1_q;
            rx_prev_q    <= rx_s2_q;
            byte_valid_q <= 1'b0;
            frame_err_q  <= 1'b0;
            case (rx_state_q)
                RX_IDLE: begin
                    if (rx_prev_q && !rx_s2_q) begin
                        rx_state_q <= RX_START;
                        rx_cnt_q   <= '0;
                    end
                end
                RX_START: begin
                    // mid-start re-sample; a high line means it was a glitch
                    if (rx_cnt_q == CNT_HALF) begin
                        rx_cnt_q   <= '0;
                        rx_bit_q   <= '0;
                        rx_state_q <= rx_s2_q ? RX_IDLE : RX_DATA;
                    end else begin
                        rx_cnt_q <= rx_cnt_q + CNT_W'(1);
                    end
                end
                RX_DATA: begin
                    if (rx_cnt_q == CNT_FULL) begin
                        rx_cnt_q   <= '0;
                        rx_shift_q <= {rx_s2_q, rx_shift_q[7:1]};
                        rx_bit_q   <= rx_bit_q + 3'd1;
                        if (rx_bit_q == 3'd7) begin
                            rx_state_q <= RX_STOP;
                        end
                    end else begin
                        rx_cnt_q <= rx_cnt_q + CNT_W'(1);
                    end
                end
                RX_STOP: begin
                    if (rx_cnt_q == CNT_FULL) begin
                        rx_cnt_q     <= '0;
                        byte_valid_q <= rx_s2_q;
                        frame_err_q  <= !rx_s2_q;
                        rx_state_q   <= RX_IDLE;
                    end else begin
                        rx_cnt_q <= rx_cnt_q + CNT_W'(1);
                    end
                end
                default: rx_state_q <= RX_IDLE;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Loader FSM
    // ------------------------------------------------------------------
    typedef enum logic [2:0] {
        L_IDLE, L_HDR, L_CNT_HI, L_CNT_LO, L_DATA, L_CSUM, L_DONE, L_ERR
    } ld_state_t;

    ld_state_t         state_q, state_d;
    logic [7:0]        cnt_hi_q;
    logic [WC_W-1:0]   n_q;
    logic [23:0]       asm_q;
    logic [1:0]        byte_idx_q;
    logic [7:0]        acc_q;
    logic [WC_W-1:0]   word_count_q;
    logic              imem_we_q;
    logic [ADDR_W-1:0] imem_addr_q;
    logic [31:0]       imem_wdata_q;
    logic              cpu_reset_q, load_done_q, load_err_q;

    logic [15:0]     n_c;
    logic [WC_W-1:0] wc_inc_c;
    logic            active_c;

    assign n_c      = {cnt_hi_q, rx_shift_q};
    assign wc_inc_c = word_count_q + WC_W'(1);
    assign active_c = (state_q == L_HDR) || (state_q == L_CNT_HI) || (state_q == L_CNT_LO) ||
                      (state_q == L_DATA) || (state_q == L_CSUM);

    // Next-state logic; an abort outranks a byte or frame error in the same cycle
    always_comb begin
        state_d = state_q;
        case (state_q)
            L_IDLE:   if (load_en) state_d = L_HDR;
            L_HDR:    if (byte_valid_q && rx_shift_q == HDR_BYTE) state_d = L_CNT_HI;
            L_CNT_HI: if (byte_valid_q) state_d = L_CNT_LO;
            L_CNT_LO: begin
                if (byte_valid_q) begin
                    if (32'(n_c) > MAX_WORDS)  state_d = L_ERR;
                    else if (n_c == 16'd0)     state_d = L_CSUM;
                    else                       state_d = L_DATA;
                end
            end
            L_DATA:   if (byte_valid_q && byte_idx_q == 2'd3 && wc_inc_c == n_q) state_d = L_CSUM;
            L_CSUM:   if (byte_valid_q) state_d = (rx_shift_q == acc_q) ? L_DONE : L_ERR;
            L_DONE:   if (!load_en) state_d = L_IDLE;
            L_ERR:    if (!load_en) state_d = L_IDLE;
            default:  state_d = L_IDLE;
        endcase
        if (active_c) begin
            if (!load_en)         state_d = L_IDLE;
            else if (frame_err_q) state_d = L_ERR;
        end
    end

    // State register, datapath and registered outputs
    always_ff @(posedge clk_in) begin
        if (reset) begin
            state_q      <= L_IDLE;
            cnt_hi_q     <= '0;
            n_q          <= '0;
            asm_q        <= '0;
            byte_idx_q   <= '0;
            acc_q        <= '0;
            word_count_q <= '0;
            imem_we_q    <= 1'b0;
            imem_addr_q  <= '0;
            imem_wdata_q <= '0;
            cpu_reset_q  <= 1'b1;
            load_done_q  <= 1'b0;
            load_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            imem_we_q   <= 1'b0;
            cpu_reset_q <= ((state_d != L_IDLE) && (state_d != L_DONE)) ||
                           ((state_d == L_IDLE) && load_en);
            if (state_q == L_IDLE && state_d == L_HDR) begin
                word_count_q <= '0;
                acc_q        <= '0;
                load_done_q  <= 1'b0;
                load_err_q   <= 1'b0;
            end
            if (state_d == L_DONE) load_done_q <= 1'b1;
            if (state_d == L_ERR)  load_err_q  <= 1'b1;
            if (byte_valid_q && load_en) begin
                case (state_q)
                    L_CNT_HI: cnt_hi_q <= rx_shift_q;
                    L_CNT_LO: begin
                        n_q        <= WC_W'(n_c);
                        byte_idx_q <= '0;
                    end
                    L_DATA: begin
                        acc_q      <= acc_q ^ rx_shift_q;
                        asm_q      <= {asm_q[15:0], rx_shift_q};
                        byte_idx_q <= byte_idx_q + 2'd1;
                        if (byte_idx_q == 2'd3) begin
                            imem_we_q    <= 1'b1;
                            imem_addr_q  <= word_count_q[ADDR_W-1:0];
                            imem_wdata_q <= {asm_q, rx_shift_q};
                            word_count_q <= wc_inc_c;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    assign imem_we    = imem_we_q;
    assign imem_addr  = imem_addr_q;
    assign imem_wdata = imem_wdata_q;
    assign cpu_reset  = cpu_reset_q;
    assign load_done  = load_done_q;
    assign load_err   = load_err_q;
    assign word_count = word_count_q;

endmodule

// File: tb/tb_imem_uart_loader.sv
// Testbench for imem_uart_loader: table of whole frames checked against
// expected end status, plus a write scoreboard fed by a small frame model.
module tb_imem_uart_loader;

    localparam int unsigned CPB = 4;
    localparam int unsigned AW  = 4;

    logic          clk_in, reset, rx, load_en;
    logic          imem_we;
    logic [AW-1:0] imem_addr;
    logic [31:0]   imem_wdata;
    logic          cpu_reset, load_done, load_err;
    logic [AW:0]   word_count;

    imem_uart_loader #(.CLKS_PER_BIT(CPB), .ADDR_W(AW)) dut (
        .clk_in(clk_in), .reset(reset), .rx(rx), .load_en(load_en),
        .imem_we(imem_we), .imem_addr(imem_addr), .imem_wdata(imem_wdata),
        .cpu_reset(cpu_reset), .load_done(load_done), .load_err(load_err),
        .word_count(word_count)
    );

    initial clk_in = 1'b0;
    always #5 clk_in = ~clk_in;

    typedef struct packed {
        logic [AW-1:0] addr;
        logic [31:0]   data;
    } wr_t;

    typedef struct {
        logic [127:0] bytes;   // left-aligned byte stream
        int           nbytes;
        logic         exp_done;
        logic         exp_err;
        logic         exp_cpurst;
        int           exp_wc;
    } row_t;

    wr_t           sb_q[$];
    row_t          rows[5];
    int            n_checks = 0;
    int            n_fail   = 0;
    logic [AW-1:0] last_addr;
    logic [31:0]   last_data;
    int            model_words;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Every write strobe must match the next expected write
    always @(negedge clk_in) begin
        if (imem_we === 1'b1) begin
            if (sb_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL unexpected_write: got addr %h data %h, expected no write", imem_addr, imem_wdata);
            end else begin
                wr_t e;
                e = sb_q.pop_front();
                check("write_addr", 32'(imem_addr), 32'(e.addr));
                check("write_data", imem_wdata, e.data);
            end
        end
    end

    task automatic send_byte(input logic [7:0] b, input logic stop_bit);
        rx = 1'b0;
        repeat (CPB) @(negedge clk_in);
        for (int i = 0; i < 8; i++) begin
            rx = b[i];
            repeat (CPB) @(negedge clk_in);
        end
        rx = stop_bit;
        repeat (CPB) @(negedge clk_in);
    endtask

    // Model: skip to header, read count, push each complete data word if the count fits
    task automatic model_frame(input logic [127:0] b, input int n);
        int i;
        int cnt;
        logic [31:0] w;
        i = 0;
        model_words = 0;
        while (i < n && b[127-8*i -: 8] != 8'h4C) i++;
        i++;
        if (i + 1 < n) begin
            cnt = {b[127-8*i -: 8], b[127-8*(i+1) -: 8]};
            i += 2;
            if (cnt <= (1 << AW)) begin
                for (int k = 0; k < cnt; k++) begin
                    if (i + 4*k + 3 < n) begin
                        w = {b[127-8*(i+4*k) -: 8], b[127-8*(i+4*k+1) -: 8],
                             b[127-8*(i+4*k+2) -: 8], b[127-8*(i+4*k+3) -: 8]};
                        sb_q.push_back('{addr: AW'(k), data: w});
                        last_addr   = AW'(k);
                        last_data   = w;
                        model_words = k + 1;
                    end
                end
            end
        end
    endtask

    task automatic send_frame(input logic [127:0] b, input int n);
        for (int k = 0; k < n; k++) send_byte(b[127-8*k -: 8], 1'b1);
    endtask

    initial begin
        // checksum of 20 08 00 05 AC 01 00 00 is 0x80
        rows[0] = '{128'h4C0002_20080005_AC010000_80_00000000, 12, 1'b1, 1'b0, 1'b0, 2};
        rows[1] = '{128'h4C0002_20080005_AC010000_00_00000000, 12, 1'b0, 1'b1, 1'b1, 2};
        rows[2] = '{128'h12FF_4C00_0000_0000_0000_0000_0000_0000, 6, 1'b1, 1'b0, 1'b0, 0};
        rows[3] = '{128'h4C00_1100_0000_0000_0000_0000_0000_0000, 3, 1'b0, 1'b1, 1'b1, 0};
        rows[4] = '{128'h4C0003DE_ADBEEF01_23456789_ABCDEF22, 16, 1'b1, 1'b0, 1'b0, 3};

        reset   = 1'b1;
        rx      = 1'b1;
        load_en = 1'b0;
        repeat (3) @(negedge clk_in);
        check("rst_imem_we",    32'(imem_we), 32'd0);
        check("rst_imem_addr",  32'(imem_addr), 32'd0);
        check("rst_imem_wdata", imem_wdata, 32'd0);
        check("rst_load_done",  32'(load_done), 32'd0);
        check("rst_load_err",   32'(load_err), 32'd0);
        check("rst_word_count", 32'(word_count), 32'd0);
        check("rst_cpu_reset",  32'(cpu_reset), 32'd1);
        reset = 1'b0;
        repeat (2) @(negedge clk_in);
        check("idle_cpu_reset", 32'(cpu_reset), 32'd0);

        load_en = 1'b1;
        @(negedge clk_in);
        check("load_en_cpu_reset", 32'(cpu_reset), 32'd1);
        load_en = 1'b0;
        repeat (3) @(negedge clk_in);

        for (int r = 0; r < 5; r++) begin
            load_en = 1'b1;
            repeat (3) @(negedge clk_in);
            model_frame(rows[r].bytes, rows[r].nbytes);
            send_frame(rows[r].bytes, rows[r].nbytes);
            repeat (8) @(negedge clk_in);
            check("row_load_done",  32'(load_done), 32'(rows[r].exp_done));
            check("row_load_err",   32'(load_err), 32'(rows[r].exp_err));
            check("row_cpu_reset",  32'(cpu_reset), 32'(rows[r].exp_cpurst));
            check("row_word_count", 32'(word_count), 32'(rows[r].exp_wc));
            check("row_writes_left", 32'(sb_q.size()), 32'd0);
            if (model_words > 0) begin
                check("row_hold_addr",  32'(imem_addr), 32'(last_addr));
                check("row_hold_wdata", imem_wdata, last_data);
            end
            load_en = 1'b0;
            repeat (3) @(negedge clk_in);
            check("row_off_cpu_reset", 32'(cpu_reset), 32'd0);
            check("row_off_load_err",  32'(load_err), 32'(rows[r].exp_err));
        end

        // Data byte with a bad stop bit
        load_en = 1'b1;
        repeat (3) @(negedge clk_in);
        send_byte(8'h4C, 1'b1);
        send_byte(8'h00, 1'b1);
        send_byte(8'h01, 1'b1);
        send_byte(8'h55, 1'b0);
        rx = 1'b1;
        repeat (8) @(negedge clk_in);
        check("ferr_load_err",   32'(load_err), 32'd1);
        check("ferr_cpu_reset",  32'(cpu_reset), 32'd1);
        check("ferr_word_count", 32'(word_count), 32'd0);
        load_en = 1'b0;
        repeat (3) @(negedge clk_in);

        // Abort after two data bytes
        load_en = 1'b1;
        repeat (3) @(negedge clk_in);
        send_byte(8'h4C, 1'b1);
        send_byte(8'h00, 1'b1);
        send_byte(8'h01, 1'b1);
        send_byte(8'hAA, 1'b1);
        send_byte(8'hBB, 1'b1);
        load_en = 1'b0;
        repeat (8) @(negedge clk_in);
        check("abort_load_err",   32'(load_err), 32'd0);
        check("abort_load_done",  32'(load_done), 32'd0);
        check("abort_cpu_reset",  32'(cpu_reset), 32'd0);
        check("abort_word_count", 32'(word_count), 32'd0);
        check("abort_writes_left", 32'(sb_q.size()), 32'd0);

        repeat (5) @(negedge clk_in);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
